// File: rtl/mcs6530_arb_pkg.sv
// Shared types and constants for the mcs6530 two-port bus arbiter.
package mcs6530_arb_pkg;

  localparam int unsigned ADDR_W             = 11;
  localparam int unsigned CHIP_A_W           = 10;
  localparam int unsigned DATA_W             = 8;
  localparam int unsigned CNT_W              = 4;
  localparam int unsigned ROM_REGION_BIT_DEF = 10;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    ERR
  } state_e;

  // Signals driven onto the 6530 pins.
  typedef struct packed {
    logic [CHIP_A_W-1:0] a;
    logic [DATA_W-1:0]   di;
    logic                we_n;
    logic                cs1;
    logic                cs2;
    logic                rs_n;
  } bus_t;

  localparam bus_t BUS_IDLE = '{
    a:    10'h000,
    di:   8'h00,
    we_n: 1'b1,
    cs1:  1'b1,
    cs2:  1'b1,
    rs_n: 1'b1
  };

  // Latched request payload.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/mcs6530_arb_pick.sv
// Winner selection with CPU priority and a starvation limit for the host port.
module mcs6530_arb_pick
  import mcs6530_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic phi2,
  input  logic rst,
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_take,
  output logic o_gnt0_c,
  output logic o_gnt1_c
);

  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_force;

  assign w_force  = (r_starve_cnt == CNT_W'(STARVE_LIMIT));
  assign o_gnt1_c = i_take & i_valid1 & (~i_valid0 | w_force);
  assign o_gnt0_c = i_take & i_valid0 & ~o_gnt1_c;

  // Count CPU wins over a waiting host; a host win clears it, saturates at the limit.
  always_ff @(posedge phi2) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (o_gnt1_c) begin
      r_starve_cnt <= '0;
    end else if (o_gnt0_c && i_valid1 && !w_force) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mcs6530_bus_arbiter.sv
// Two-port arbiter sequencing CPU and host accesses onto a single mcs6530 bus.
module mcs6530_bus_arbiter
  import mcs6530_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned ROM_REGION_BIT = ROM_REGION_BIT_DEF
) (
  input  logic                phi2,
  input  logic                rst,
  input  logic                req0_valid,
  input  logic                req0_we,
  input  logic [ADDR_W-1:0]   req0_addr,
  input  logic [DATA_W-1:0]   req0_wdata,
  output logic                req0_ready,
  output logic                rsp0_valid,
  output logic [DATA_W-1:0]   rsp0_rdata,
  output logic                rsp0_err,
  input  logic                req1_valid,
  input  logic                req1_we,
  input  logic [ADDR_W-1:0]   req1_addr,
  input  logic [DATA_W-1:0]   req1_wdata,
  output logic                req1_ready,
  output logic                rsp1_valid,
  output logic [DATA_W-1:0]   rsp1_rdata,
  output logic                rsp1_err,
  output logic [CHIP_A_W-1:0] bus_A,
  output logic [DATA_W-1:0]   bus_DI,
  output logic                bus_we_n,
  output logic                bus_CS1,
  output logic                bus_CS2,
  output logic                bus_RS_n,
  input  logic [DATA_W-1:0]   bus_DO
);

  state_e            r_state, w_state_nxt;
  req_t              r_req, w_req_nxt, w_sel_req;
  logic              r_port, w_port_nxt;
  bus_t              r_bus, w_bus_nxt;
  logic              r_rsp0_valid, w_rsp0_valid_nxt;
  logic              r_rsp1_valid, w_rsp1_valid_nxt;
  logic              r_rsp0_err, w_rsp0_err_nxt;
  logic              r_rsp1_err, w_rsp1_err_nxt;
  logic [DATA_W-1:0] r_rsp0_rdata, w_rsp0_rdata_nxt;
  logic [DATA_W-1:0] r_rsp1_rdata, w_rsp1_rdata_nxt;
  logic [DATA_W-1:0] w_rsp_data;
  logic              w_take, w_gnt0, w_gnt1;

  // Grants are only offered from IDLE and never while reset is applied.
  assign w_take = (r_state == IDLE) & ~rst;

  mcs6530_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .phi2     (phi2),
    .rst      (rst),
    .i_valid0 (req0_valid),
    .i_valid1 (req1_valid),
    .i_take   (w_take),
    .o_gnt0_c (w_gnt0),
    .o_gnt1_c (w_gnt1)
  );

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign w_sel_req  = w_gnt1 ? '{we: req1_we, addr: req1_addr, wdata: req1_wdata}
                             : '{we: req0_we, addr: req0_addr, wdata: req0_wdata};

  // State register.
  always_ff @(posedge phi2) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, bus drive for the following cycle, and response generation.
  always_comb begin
    w_state_nxt      = r_state;
    w_req_nxt        = r_req;
    w_port_nxt       = r_port;
    w_bus_nxt        = BUS_IDLE;
    w_rsp0_valid_nxt = 1'b0;
    w_rsp1_valid_nxt = 1'b0;
    w_rsp0_err_nxt   = 1'b0;
    w_rsp1_err_nxt   = 1'b0;
    w_rsp0_rdata_nxt = r_rsp0_rdata;
    w_rsp1_rdata_nxt = r_rsp1_rdata;
    w_rsp_data       = 8'h00;
    unique case (r_state)
      IDLE: begin
        if (w_gnt0 || w_gnt1) begin
          w_req_nxt  = w_sel_req;
          w_port_nxt = w_gnt1;
          if (w_sel_req.addr[ROM_REGION_BIT]) begin
            if (w_sel_req.we) begin
              w_state_nxt = ERR;
            end else begin
              w_state_nxt    = ISSUE;
              w_bus_nxt.a    = w_sel_req.addr[CHIP_A_W-1:0];
              w_bus_nxt.rs_n = 1'b0;
              w_bus_nxt.cs2  = 1'b0;
            end
          end else begin
            w_state_nxt    = ISSUE;
            w_bus_nxt.a    = w_sel_req.addr[CHIP_A_W-1:0];
            w_bus_nxt.cs1  = 1'b0;
            w_bus_nxt.we_n = ~w_sel_req.we;
            w_bus_nxt.di   = w_sel_req.we ? w_sel_req.wdata : 8'h00;
          end
        end
      end
      ISSUE: begin
        w_state_nxt = CAPTURE;
      end
      CAPTURE: begin
        w_state_nxt = IDLE;
        w_rsp_data  = r_req.we ? 8'h00 : bus_DO;
        if (r_port) begin
          w_rsp1_valid_nxt = 1'b1;
          w_rsp1_rdata_nxt = w_rsp_data;
        end else begin
          w_rsp0_valid_nxt = 1'b1;
          w_rsp0_rdata_nxt = w_rsp_data;
        end
      end
      ERR: begin
        w_state_nxt = IDLE;
        if (r_port) begin
          w_rsp1_valid_nxt = 1'b1;
          w_rsp1_err_nxt   = 1'b1;
          w_rsp1_rdata_nxt = 8'h00;
        end else begin
          w_rsp0_valid_nxt = 1'b1;
          w_rsp0_err_nxt   = 1'b1;
          w_rsp0_rdata_nxt = 8'h00;
        end
      end
      default: ;
    endcase
  end

  // Registered request latch, bus pins and response outputs.
  always_ff @(posedge phi2) begin
    if (rst) begin
      r_req        <= '0;
      r_port       <= 1'b0;
      r_bus        <= BUS_IDLE;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_err   <= 1'b0;
      r_rsp1_err   <= 1'b0;
      r_rsp0_rdata <= 8'h00;
      r_rsp1_rdata <= 8'h00;
    end else begin
      r_req        <= w_req_nxt;
      r_port       <= w_port_nxt;
      r_bus        <= w_bus_nxt;
      r_rsp0_valid <= w_rsp0_valid_nxt;
      r_rsp1_valid <= w_rsp1_valid_nxt;
      r_rsp0_err   <= w_rsp0_err_nxt;
      r_rsp1_err   <= w_rsp1_err_nxt;
      r_rsp0_rdata <= w_rsp0_rdata_nxt;
      r_rsp1_rdata <= w_rsp1_rdata_nxt;
    end
  end

  assign bus_A      = r_bus.a;
  assign bus_DI     = r_bus.di;
  assign bus_we_n   = r_bus.we_n;
  assign bus_CS1    = r_bus.cs1;
  assign bus_CS2    = r_bus.cs2;
  assign bus_RS_n   = r_bus.rs_n;
  assign rsp0_valid = r_rsp0_valid;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp0_err   = r_rsp0_err;
  assign rsp1_err   = r_rsp1_err;
  assign rsp0_rdata = r_rsp0_rdata;
  assign rsp1_rdata = r_rsp1_rdata;

endmodule

// File: tb/tb_mcs6530_bus_arbiter.sv
// Directed bench for mcs6530_bus_arbiter with a small behavioural 6530 model.
module tb_mcs6530_bus_arbiter;

  logic        phi2 = 1'b0;
  logic        rst  = 1'b1;
  logic        req0_valid = 1'b0, req0_we = 1'b0;
  logic [10:0] req0_addr  = '0;
  logic [7:0]  req0_wdata = '0;
  logic        req0_ready, rsp0_valid, rsp0_err;
  logic [7:0]  rsp0_rdata;
  logic        req1_valid = 1'b0, req1_we = 1'b0;
  logic [10:0] req1_addr  = '0;
  logic [7:0]  req1_wdata = '0;
  logic        req1_ready, rsp1_valid, rsp1_err;
  logic [7:0]  rsp1_rdata;
  logic [9:0]  bus_A;
  logic [7:0]  bus_DI;
  logic        bus_we_n, bus_CS1, bus_CS2, bus_RS_n;
  logic [7:0]  bus_DO = 8'h00;

  int n_tests = 0;
  int n_fail  = 0;

  mcs6530_bus_arbiter #(.STARVE_LIMIT(4), .ROM_REGION_BIT(10)) dut (
    .phi2(phi2), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .rsp0_valid(rsp0_valid),
    .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .rsp1_valid(rsp1_valid),
    .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .bus_A(bus_A), .bus_DI(bus_DI), .bus_we_n(bus_we_n), .bus_CS1(bus_CS1),
    .bus_CS2(bus_CS2), .bus_RS_n(bus_RS_n), .bus_DO(bus_DO)
  );

  always #5 phi2 = ~phi2;

  // 6530 model: ROM image is addr[7:0]^0x5A; RAM/IO is a plain array; DO is registered.
  logic [7:0] ram [0:1023] = '{default: 8'h00};
  always @(posedge phi2) begin
    if (rst) ram[10'h3C5] <= 8'hA7;
    if (!bus_CS1) begin
      if (!bus_we_n) begin
        ram[bus_A] <= bus_DI;
        bus_DO     <= bus_DI;
      end else begin
        bus_DO <= ram[bus_A];
      end
    end else if (!bus_RS_n && !bus_CS2) begin
      bus_DO <= bus_A[7:0] ^ 8'h5A;
    end else begin
      bus_DO <= 8'hEE;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       port;
    logic       we;
    logic [10:0] addr;
    logic [7:0] wdata;
    logic       err;
    logic [9:0] a;
    logic       cs1, cs2, rs_n, we_n;
    logic [7:0] di;
    logic [7:0] rdata;
  } vec_t;

  function automatic vec_t mk(input logic port, input logic we, input logic [10:0] addr,
                              input logic [7:0] wdata, input logic err, input logic [9:0] a,
                              input logic cs1, input logic cs2, input logic rs_n,
                              input logic we_n, input logic [7:0] di, input logic [7:0] rdata);
    vec_t v;
    v.port = port; v.we = we; v.addr = addr; v.wdata = wdata; v.err = err; v.a = a;
    v.cs1 = cs1; v.cs2 = cs2; v.rs_n = rs_n; v.we_n = we_n; v.di = di; v.rdata = rdata;
    return v;
  endfunction

  task automatic drive(input logic port, input logic v, input logic we,
                       input logic [10:0] addr, input logic [7:0] wdata);
    if (port) begin
      req1_valid = v; req1_we = we; req1_addr = addr; req1_wdata = wdata;
    end else begin
      req0_valid = v; req0_we = we; req0_addr = addr; req0_wdata = wdata;
    end
  endtask

  task automatic check_bus_idle(input string tag);
    check({tag, ".A_idle"},    32'(bus_A), 32'h000);
    check({tag, ".DI_idle"},   32'(bus_DI), 32'h00);
    check({tag, ".pins_idle"}, {28'h0, bus_we_n, bus_CS1, bus_CS2, bus_RS_n}, 32'hF);
  endtask

  // Issue one request from an IDLE arbiter and check bus cycle and response timing.
  task automatic run_vec(input vec_t v, input string tag);
    int  waited = 0;
    bit  got = 0;
    drive(v.port, 1'b1, v.we, v.addr, v.wdata);
    for (int c = 0; c < 20; c++) begin
      @(negedge phi2);
      if (v.port ? req1_ready : req0_ready) begin
        got = 1;
        check({tag, ".other_ready"}, 32'(v.port ? req0_ready : req1_ready), 0);
        break;
      end
      waited++;
      @(posedge phi2); #1;
    end
    if (!got) begin
      check({tag, ".accept_timeout"}, 0, 1);
      drive(v.port, 1'b0, 1'b0, 11'h0, 8'h0);
      return;
    end
    check({tag, ".accept_wait"}, 32'(waited), 0);
    @(posedge phi2); #1;
    drive(v.port, 1'b0, 1'b0, 11'h0, 8'h0);
    if (v.err) begin
      check_bus_idle({tag, ".n1"});
      check({tag, ".n1_rsp"}, 32'(rsp0_valid | rsp1_valid), 0);
    end else begin
      check({tag, ".A"},    32'(bus_A), 32'(v.a));
      check({tag, ".DI"},   32'(bus_DI), 32'(v.di));
      check({tag, ".pins"}, {28'h0, bus_we_n, bus_CS1, bus_CS2, bus_RS_n},
            {28'h0, v.we_n, v.cs1, v.cs2, v.rs_n});
      @(posedge phi2); #1;
      check_bus_idle({tag, ".n2"});
      check({tag, ".n2_rsp"}, 32'(rsp0_valid | rsp1_valid), 0);
    end
    @(posedge phi2); #1;
    check({tag, ".rsp_valid"}, 32'(v.port ? rsp1_valid : rsp0_valid), 1);
    check({tag, ".other_rsp"}, 32'(v.port ? rsp0_valid : rsp1_valid), 0);
    check({tag, ".rsp_err"},   32'(v.port ? rsp1_err : rsp0_err), 32'(v.err));
    check({tag, ".rdata"},     32'(v.port ? rsp1_rdata : rsp0_rdata), 32'(v.rdata));
  endtask

  vec_t vecs[8];
  int   exp_order[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //            port we  addr     wdata err a       cs1 cs2 rsn wen di     rdata
    vecs[0] = mk(0, 0, 11'h3C5, 8'h00, 0, 10'h3C5, 0, 1, 1, 1, 8'h00, 8'hA7);
    vecs[1] = mk(1, 1, 11'h400, 8'h55, 1, 10'h000, 1, 1, 1, 1, 8'h00, 8'h00);
    vecs[2] = mk(1, 0, 11'h412, 8'h00, 0, 10'h012, 1, 0, 0, 1, 8'h00, 8'h48);
    vecs[3] = mk(0, 1, 11'h201, 8'hFF, 0, 10'h201, 0, 1, 1, 0, 8'hFF, 8'h00);
    vecs[4] = mk(0, 0, 11'h201, 8'h00, 0, 10'h201, 0, 1, 1, 1, 8'h00, 8'hFF);
    vecs[5] = mk(1, 1, 11'h07F, 8'h3C, 0, 10'h07F, 0, 1, 1, 0, 8'h3C, 8'h00);
    vecs[6] = mk(1, 0, 11'h07F, 8'h00, 0, 10'h07F, 0, 1, 1, 1, 8'h00, 8'h3C);
    vecs[7] = mk(0, 0, 11'h7FF, 8'h00, 0, 10'h3FF, 1, 0, 0, 1, 8'h00, 8'hA5);

    // Reset state, with a request held during reset that must not be accepted.
    rst = 1'b1;
    drive(0, 1'b1, 1'b0, 11'h3C5, 8'h00);
    repeat (3) @(posedge phi2);
    #1;
    check("reset.ready0", 32'(req0_ready), 0);
    check("reset.ready1", 32'(req1_ready), 0);
    check("reset.rsp", {28'h0, rsp0_valid, rsp0_err, rsp1_valid, rsp1_err}, 0);
    check("reset.rdata", {16'h0, rsp0_rdata, rsp1_rdata}, 0);
    check_bus_idle("reset");
    drive(0, 1'b0, 1'b0, 11'h0, 8'h0);
    rst = 1'b0;
    @(posedge phi2); #1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset while a port-0 write is on the bus: the transaction is dropped.
    begin
      bit got = 0;
      bit stray = 0;
      drive(0, 1'b1, 1'b1, 11'h0A0, 8'h77);
      for (int c = 0; c < 10 && !got; c++) begin
        @(negedge phi2);
        got = req0_ready;
        @(posedge phi2); #1;
      end
      check("rst_mid.accepted", 32'(got), 1);
      drive(0, 1'b0, 1'b0, 11'h0, 8'h0);
      check("rst_mid.issue_we_n", 32'(bus_we_n), 0);
      rst = 1'b1;
      @(posedge phi2); #1;
      check_bus_idle("rst_mid");
      check("rst_mid.starve_cnt", 32'(dut.u_pick.r_starve_cnt), 0);
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
        @(posedge phi2); #1;
        if (rsp0_valid || rsp1_valid) stray = 1;
      end
      check("rst_mid.no_rsp", 32'(stray), 0);
      run_vec(vecs[0], "rst_mid.after");
    end

    // Both ports continuously valid: starvation limit forces every fifth grant to port 1.
    begin
      int  order[$];
      bit  both_rdy = 0;
      bit  both_rsp = 0;
      rst = 1'b1;
      @(posedge phi2); #1;
      rst = 1'b0;
      drive(0, 1'b1, 1'b0, 11'h3C5, 8'h00);
      drive(1, 1'b1, 1'b0, 11'h412, 8'h00);
      for (int c = 0; c < 200 && order.size() < 10; c++) begin
        @(negedge phi2);
        if (req0_ready && req1_ready) both_rdy = 1;
        if (rsp0_valid && rsp1_valid) both_rsp = 1;
        if (req0_ready) order.push_back(0);
        else if (req1_ready) order.push_back(1);
        @(posedge phi2); #1;
      end
      drive(0, 1'b0, 1'b0, 11'h0, 8'h0);
      drive(1, 1'b0, 1'b0, 11'h0, 8'h0);
      check("arb.grant_count", 32'(order.size()), 10);
      for (int i = 0; i < 10; i++) begin
        if (i < order.size()) check($sformatf("arb.grant%0d", i), 32'(order[i]), 32'(exp_order[i]));
      end
      check("arb.two_readies", 32'(both_rdy), 0);
      check("arb.two_rsps", 32'(both_rsp), 0);
      repeat (4) @(posedge phi2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
